countdown_timer_bcd: RTL and testbench
======================================

// Module: countdown_timer_bcd
// PURPOSE
//  Programmable 4-digit BCD countdown timer (SS.cc, 10 ms resolution). This is the
//  count-down counterpart of the start/stop stopwatch. It loads a preset from the
//  switches and decrements at 100 Hz. It raises an alarm at zero and drives the
//  LED multiplexer with the remaining time. Raw pushbuttons are synchronised and
//  debounced internally.
// PARAMETERS
//  TICK_PERIOD      500000  CLK_50M cycles per 10 ms tick (100 Hz at 50 MHz)
//  DEBOUNCE_CYCLES  500000  cycles a synced button level must stay stable to be accepted
//  ALARM_TICKS      200     ticks the alarm output stays high in EXPIRED (2 s)
// PORTS
//  CLK_50M         in   1   single system clock, all logic on rising edge
//  reset_n         in   1   asynchronous, active-low reset
//  btn_start_stop  in   1   raw pushbutton: start / pause / resume / alarm acknowledge
//  btn_load        in   1   raw pushbutton: load preset, return to IDLE
//  preset          in   16  BCD {tens_s, units_s, deci_s, centi_s}
//  digits          out  16  remaining time in BCD, same nibble order as preset
//  state           out  2   00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED
//  running         out  1   1 iff state==RUN
//  alarm           out  1   high while in EXPIRED, until timeout or acknowledge
// BEHAVIOUR
//  Reset (async assert, sync release): digits=0000, state=IDLE, running=0, alarm=0.
//   Tick counter=0, alarm counter=0, both button sync/debounce chains = released.
//  Buttons: 2-FF synchroniser, then debouncer. The debounced level changes only after
//   the synced level differs from it for DEBOUNCE_CYCLES consecutive cycles.
//   A 0->1 edge of the debounced level yields a 1-cycle press pulse. Release makes no pulse.
//  All outputs are registered. Effect is visible 1 cycle after the press/tick pulse.
//  Tick counter: runs only in RUN. Cleared on IDLE->RUN. Held (not cleared) in PAUSE.
//   It also counts in EXPIRED for the alarm timeout. Tick pulse fires when count==TICK_PERIOD-1, then wraps to 0.
//  Priority per cycle: reset_n > load press > start press > tick.
//  Load press (any state): digits<=preset with each nibble >9 clamped to 9.
//   Also state<=IDLE, alarm<=0, tick counter<=0.
//  IDLE: start press with digits!=0000 -> RUN. Start press with digits==0000 is ignored.
//  RUN: start press -> PAUSE. A tick in the same cycle is still applied (decrement + PAUSE).
//   On tick: BCD decrement with borrow across nibbles (e.g. 1000->0999, 0100->0099).
//   If the decremented result is 0000 -> EXPIRED, alarm<=1, alarm counter<=0.
//  PAUSE: digits frozen. Start press -> RUN, tick counter resumes from its held value.
//  EXPIRED: digits=0000. Alarm counter increments per tick.
//   When it reaches ALARM_TICKS: alarm<=0, state<=IDLE.
//   Start press -> alarm<=0, state<=IDLE at once (acknowledge).
//  digits never wraps below 0000 and never takes a non-BCD value.
//  Reset mid-operation aborts immediately to reset values. No pending press survives reset.
// TESTING (bench params: TICK_PERIOD=4, DEBOUNCE_CYCLES=3, ALARM_TICKS=2)
//  1 preset=0012, load, start -> digits 0011,0010,...,0000 every 4 cycles.
//    At 0000 state=11, alarm=1 for 2 ticks (8 cycles), then state=00, alarm=0.
//  2 preset=1000 then 0100, run one tick each -> digits 0999 and 0099 (borrow chain).
//  3 start bounces: 2-cycle high glitches separated by lows -> no state change.
//    One stable 3+ cycle press -> exactly one IDLE->RUN.
//  4 run 2 ticks, pause -> digits frozen 20 ticks. Resume -> next decrement after remaining
//    tick cycles only. Start press coinciding with a tick -> decremented value + PAUSE.
//  5 RUN, then load with preset=0A5F -> digits=0959, state=IDLE.
//    Load with preset 0000, then start -> stays IDLE, running=0.
//  6 reset_n low mid-RUN and mid-EXPIRED -> digits=0000, state=00, alarm=0 asynchronously.
//    Button held through reset release -> requires full debounce before it registers.

Source files
------------

// File: rtl/countdown_timer_bcd_if.sv
// countdown_timer_bcd_if: button, preset and display bundle of the BCD countdown timer
// Signals:
//   btn_start_stop  raw start / pause / resume / acknowledge pushbutton
//   btn_load        raw load-preset pushbutton
//   preset[15:0]    BCD preset {tens_s, units_s, deci_s, centi_s}
//   digits[15:0]    remaining time in BCD, same nibble order as preset
//   state[1:0]      00 IDLE, 01 RUN, 10 PAUSE, 11 EXPIRED
//   running         high iff state is RUN
//   alarm           high while expired until timeout or acknowledge
// master drives buttons and preset; slave (the timer) drives the display side.
interface countdown_timer_bcd_if;
    logic        btn_start_stop;
    logic        btn_load;
    logic [15:0] preset;
    logic [15:0] digits;
    logic [1:0]  state;
    logic        running;
    logic        alarm;
    modport master (output btn_start_stop, btn_load, preset, input digits, state, running, alarm);
    modport slave  (input btn_start_stop, btn_load, preset, output digits, state, running, alarm);
endinterface

// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd: 4-digit BCD countdown timer (SS.cc) with debounced buttons and alarm
// Ports:
//   CLK_50M   system clock, rising edge
//   reset_n   asynchronous active-low reset, synchronous release
//   bus       countdown_timer_bcd_if.slave: raw buttons and preset in, digits/state/running/alarm out
module countdown_timer_bcd #(
    parameter int TICK_PERIOD     = 500000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ALARM_TICKS     = 200
) (
    input logic                  CLK_50M,
    input logic                  reset_n,
    countdown_timer_bcd_if.slave bus
);
    localparam int TW = $clog2(TICK_PERIOD + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(ALARM_TICKS + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, EXPIRED = 2'b11} state_t;

    state_t        st;
    logic [15:0]   digits;
    logic          running;
    logic          alarm;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] alarm_cnt;
    logic [1:0]    raw, s1, s2, deb, deb_d, press;
    logic [DW-1:0] dcnt [2];
    logic          start_p, load_p, tick;
    logic [15:0]   dec, clamped;

    // Only called with a nonzero value, so the borrow never runs off the top digit.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                borrow = v[4*i+:4] == 4'd0;
                r[4*i+:4] = borrow ? 4'd9 : v[4*i+:4] - 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i+:4] = v[4*i+:4] > 4'd9 ? 4'd9 : v[4*i+:4];
        return r;
    endfunction

    assign raw     = {bus.btn_load, bus.btn_start_stop};
    assign press   = deb & ~deb_d;
    assign start_p = press[0];
    assign load_p  = press[1];
    assign tick    = (st == RUN || st == EXPIRED) && tick_cnt == TW'(TICK_PERIOD - 1);
    assign dec     = bcd_dec(digits);
    assign clamped = bcd_clamp(bus.preset);

    // Per button: 2-FF synchroniser, then the debounced level follows the synced level
    // only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            deb     <= '0;
            deb_d   <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge reset_n) begin
        if (!reset_n) begin
            st        <= IDLE;
            digits    <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            tick_cnt  <= '0;
            alarm_cnt <= '0;
        end else begin
            if (st == RUN || st == EXPIRED) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (load_p) begin
                digits   <= clamped;
                st       <= IDLE;
                running  <= 1'b0;
                alarm    <= 1'b0;
                tick_cnt <= '0;
            end else begin
                case (st)
                    IDLE: if (start_p && digits != '0) begin
                        st       <= RUN;
                        running  <= 1'b1;
                        tick_cnt <= '0;
                    end
                    RUN: begin
                        if (tick) digits <= dec;
                        // Reaching zero wins over a simultaneous pause request.
                        if (tick && dec == '0) begin
                            st        <= EXPIRED;
                            running   <= 1'b0;
                            alarm     <= 1'b1;
                            alarm_cnt <= '0;
                        end else if (start_p) begin
                            st      <= PAUSE;
                            running <= 1'b0;
                        end
                    end
                    PAUSE: if (start_p) begin
                        st      <= RUN;
                        running <= 1'b1;
                    end
                    EXPIRED: begin
                        if (start_p || (tick && alarm_cnt == AW'(ALARM_TICKS - 1))) begin
                            st    <= IDLE;
                            alarm <= 1'b0;
                        end else if (tick) begin
                            alarm_cnt <= alarm_cnt + AW'(1);
                        end
                    end
                endcase
            end
        end
    end

    assign bus.digits  = digits;
    assign bus.state   = st;
    assign bus.running = running;
    assign bus.alarm   = alarm;
endmodule

// File: tb/tb_countdown_timer_bcd.sv
// tb_countdown_timer_bcd: scoreboard bench with a remaining-time reference model
module tb_countdown_timer_bcd;
    localparam int TP = 4;
    localparam int DC = 3;
    localparam int AT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    countdown_timer_bcd_if bus();

    countdown_timer_bcd #(.TICK_PERIOD(TP), .DEBOUNCE_CYCLES(DC), .ALARM_TICKS(AT)) dut (
        .CLK_50M(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [19:0] expq [$];

    // Reference model: remaining time is a plain integer count of centiseconds.
    int rem = 0, mst = 0, tc = 0, acnt = 0;
    bit alm = 0;
    bit s1 [2], s2 [2], deb [2], debd [2];
    int dis [2];

    function automatic int preset_val(input logic [15:0] p);
        int v = 0;
        for (int i = 3; i >= 0; i--) begin
            int n = int'((p >> (4 * i)) & 16'hF);
            v = v * 10 + (n > 9 ? 9 : n);
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    always @(posedge clk) begin
        bit ps, pl, tk;
        bit raw [2];
        if (!reset_n) begin
            rem = 0; mst = 0; tc = 0; acnt = 0; alm = 0;
            for (int i = 0; i < 2; i++) begin
                s1[i] = 0; s2[i] = 0; deb[i] = 0; debd[i] = 0; dis[i] = 0;
            end
        end else begin
            raw[0] = bus.btn_start_stop;
            raw[1] = bus.btn_load;
            ps = deb[0] && !debd[0];
            pl = deb[1] && !debd[1];
            tk = (mst == 1 || mst == 3) && tc == TP - 1;
            if (mst == 1 || mst == 3) tc = (tc + 1) % TP;
            if (pl) begin
                rem = preset_val(bus.preset); mst = 0; alm = 0; tc = 0;
            end else if (mst == 0) begin
                if (ps && rem != 0) begin mst = 1; tc = 0; end
            end else if (mst == 1) begin
                if (tk) rem = rem - 1;
                if (tk && rem == 0) begin mst = 3; alm = 1; acnt = 0; end
                else if (ps) mst = 2;
            end else if (mst == 2) begin
                if (ps) mst = 1;
            end else begin
                if (ps) begin mst = 0; alm = 0; end
                else if (tk) begin
                    acnt++;
                    if (acnt == AT) begin mst = 0; alm = 0; end
                end
            end
            for (int i = 0; i < 2; i++) begin
                debd[i] = deb[i];
                dis[i] = (s2[i] != deb[i]) ? dis[i] + 1 : 0;
                if (dis[i] == DC) begin deb[i] = s2[i]; dis[i] = 0; end
                s2[i] = s1[i];
                s1[i] = raw[i];
            end
        end
        expq.push_back({to_bcd(rem), 2'(mst), mst == 1, alm});
    end

    always @(negedge clk) begin
        logic [19:0] want, got;
        if (expq.size() > 0) begin
            want = expq.pop_front();
            if (!reset_n) want = '0;
            got = {bus.digits, bus.state, bus.running, bus.alarm};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL outputs @%0t: got digits=%h state=%0d running=%0b alarm=%0b, expected digits=%h state=%0d running=%0b alarm=%0b",
                         $time, got[19:4], got[3:2], got[1], got[0], want[19:4], want[3:2], want[1], want[0]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_btn(input bit ld, input int len);
        if (ld) bus.btn_load = 1'b1; else bus.btn_start_stop = 1'b1;
        cyc(len);
        bus.btn_load = 1'b0;
        bus.btn_start_stop = 1'b0;
        cyc(5);
    endtask

    task automatic load(input logic [15:0] p);
        bus.preset = p;
        push_btn(1, 4);
    endtask

    task automatic async_reset(input int hold);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 checks++;
        if ({bus.digits, bus.state, bus.running, bus.alarm} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset: got digits=%h state=%0d running=%0b alarm=%0b, expected all zero",
                     bus.digits, bus.state, bus.running, bus.alarm);
        end
        cyc(hold);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.btn_start_stop = 1'b0;
        bus.btn_load = 1'b0;
        bus.preset = '0;
        cyc(3);
        reset_n = 1'b1;
        cyc(2);
        // full countdown, expiry and alarm timeout
        load(16'h0012);
        push_btn(0, 4);
        cyc(70);
        // borrow chains
        load(16'h1000);
        push_btn(0, 4);
        cyc(6);
        load(16'h0100);
        push_btn(0, 4);
        cyc(6);
        // bouncing start: only glitches, then one clean press
        load(16'h0005);
        repeat (3) begin
            bus.btn_start_stop = 1'b1; cyc(2);
            bus.btn_start_stop = 1'b0; cyc(2);
        end
        cyc(6);
        push_btn(0, 4);
        cyc(10);
        // pause / resume, and pause landing on tick boundaries at each phase
        load(16'h0050);
        push_btn(0, 4);
        cyc(3);
        push_btn(0, 4);
        cyc(80);
        push_btn(0, 4);
        cyc(12);
        for (int off = 0; off < 4; off++) begin
            load(16'h0030);
            push_btn(0, 4);
            cyc(off);
            push_btn(0, 4);
        end
        // clamped load from RUN, zero preset start ignored
        push_btn(0, 4);
        load(16'h0A5F);
        load(16'h0000);
        push_btn(0, 4);
        cyc(4);
        // reset mid-RUN and mid-EXPIRED
        load(16'h0020);
        push_btn(0, 4);
        cyc(10);
        async_reset(2);
        cyc(2);
        load(16'h0002);
        push_btn(0, 4);
        cyc(4);
        async_reset(3);
        // load held through reset release needs a full debounce
        bus.preset = 16'h0005;
        @(posedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        bus.btn_load = 1'b1;
        cyc(1);
        reset_n = 1'b1;
        cyc(8);
        bus.btn_load = 1'b0;
        cyc(6);
        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int r = $urandom_range(0, 9);
            if (r <= 3) cyc($urandom_range(1, 12));
            else if (r <= 6) push_btn(0, $urandom_range(1, 6));
            else if (r <= 8) begin
                bus.preset = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 9));
                push_btn(1, $urandom_range(1, 6));
            end else if ($urandom_range(0, 4) == 0) async_reset($urandom_range(1, 3));
            else cyc(30);
        end
        cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
